shift_barrelpipe_rleft: RTL and testbench
=========================================

Name: shift_barrelpipe_rleft

Overview:
Pipelined rotate-left barrel shifter, the left-direction counterpart of the combinational rotate-right shifter in ware/rtl. One rotate level per pipeline stage: stage k rotates by 2^k when shift bit k is set. Latency is log2(Bits) cycles, throughput one result per cycle. Valid/retry handshake on both sides, so it drops into the ware datapaths between retry-based FIFOs.

Parameters:
Bits, 64, data width; must be a power of 2 and >= 2.
Log, `log2(Bits), number of rotate levels, equal to the pipeline depth; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_a/in_sh hold a request.
in_retry  output  1  request not accepted this cycle; the producer holds it.
in_a  input  Bits  data to rotate.
in_sh  input  Log  left-rotate amount, 0..Bits-1.
out_valid  output  1  out_b holds a result.
out_retry  input  1  consumer cannot take the result this cycle.
out_b  output  Bits  in_a rotated left by in_sh.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - all stage valid bits = 0, all stage data and shift registers = 0.
  - out_valid = 0, out_b = 0, in_retry = 0.
- Stage k (k = 0..Log-1) holds the register triple {v_k, d_k, s_k}.
  - On load, d_k = s_{k-1}[k] ? rotl(d_{k-1}, 2^k) : d_{k-1}.
  - Stage 0 loads from in_a and in_sh.
  - s_k carries the full shift amount forward; only bit k is consumed at stage k.
- rotl(x, n) = {x[Bits-1-n:0], x[Bits-1:Bits-n]}. No bits are lost. Shift 0 is a pass-through.
- Outputs: out_valid = v_{Log-1}, out_b = d_{Log-1}.
- Advance rule (bubble-collapsing):
  - rdy_Log = !out_retry.
  - rdy_k = !v_k || rdy_{k+1}.
  - Stage k loads when rdy_k. It sets v_k = v_{k-1}, with v_{-1} = in_valid.
  - When v_{k-1} = 0 and rdy_k = 1, v_k clears; the data registers may hold stale values.
  - When rdy_k = 0, the stage holds all of its registers.
- in_retry = !rdy_0. This is combinational from out_retry through a Log-deep AND/OR chain; that path is accepted.
- Handshake:
  - A request transfers on a cycle with in_valid && !in_retry.
  - A result transfers on a cycle with out_valid && !out_retry.
  - out_b stays stable while out_valid && out_retry.
- Latency:
  - A request accepted in cycle t appears with out_valid in cycle t+Log, if no stall occurs.
  - Each stall cycle at the output adds one cycle.
  - Empty stages collapse, so a stalled pipeline refills without bubbles.
- Capacity is Log entries. When full and stalled, in_retry = 1.
- Ordering is strictly FIFO, with no drop and no duplication.
- in_valid while in_retry = 1: nothing is captured. The next accept takes the then-current inputs.
- Reset asserted mid-operation: all in-flight requests are discarded and out_valid drops in the same cycle.
- in_sh is always in range by width; no saturation logic is needed.

Decomposition:
- Shared package (ware shift package): Bits default, the `log2-based Log constant, and the stage record typedef {valid, data[Bits-1:0], sh[Log-1:0]}.
- rotl is a function in the package.
- One sub-module is natural: shift_rleft_stage.
  - Parameters: Bits and level K.
  - Contents: one conditional rotate by 2^K, the registered triple, and the rdy_in/rdy_out logic.
- The top module instantiates Log of these stages in a generate loop and wires the ready chain.

Test Plan:
- Bits=64, in_a=0x0123456789ABCDEF, in_sh=4, out_retry=0 -> out_valid 6 cycles after accept, out_b=0x123456789ABCDEF0.
- in_sh=0 and in_sh=63 on 0x8000000000000001 -> 0x8000000000000001, then 0xC000000000000000 (rotl by 63 equals rotr by 1).
- 100 back-to-back random requests, out_retry=0 -> one result per cycle after the 6-cycle fill, all matching a reference model, in order.
- Hold out_retry=1 for 10 cycles during a stream -> in_retry=1 once 6 entries are held, out_b stable, no loss or duplication; after release, 6 results drain back-to-back.
- Pulse reset_n low for 1 cycle with 4 requests in flight -> out_valid=0 and out_b=0 immediately; no stale result emerges afterwards.
- Bits=8 (Log=3), in_a=0xA5, in_sh=3 -> out_b=0x2D, 3 cycles after accept.

Source files
------------

// File: rtl/shift_barrelpipe_rleft_pkg.sv
// Shared definitions for the pipelined rotate-left barrel shifter:
// default width, derived level count, stage record and the rotate helper.
package shift_barrelpipe_rleft_pkg;

  localparam int BITS_DFLT = 64;
  localparam int LOG_DFLT  = $clog2(BITS_DFLT);

  // Widest data path the generic rotate helper can serve.
  localparam int ROT_MAX = 1024;

  // One pipeline stage at the default width: valid flag, data, full shift amount.
  typedef struct packed {
    logic                valid;
    logic [BITS_DFLT-1:0] data;
    logic [LOG_DFLT-1:0]  sh;
  } stage_t;

  // Rotate the low 'bits' bits of x left by n (n < bits); upper bits return as zero.
  // Callers pass constant n and bits, so this reduces to pure wiring.
  function automatic logic [ROT_MAX-1:0] rotl(input logic [ROT_MAX-1:0] x,
                                               input int unsigned       n,
                                               input int unsigned       bits);
    logic [ROT_MAX-1:0] ones;
    logic [ROT_MAX-1:0] mask;
    ones = '1;
    mask = ones >> (ROT_MAX - bits);
    return ((x << n) | (x >> (bits - n))) & mask;
  endfunction

endpackage

// File: rtl/shift_barrelpipe_rleft_stage.sv
// One level of the rotate-left pipeline: conditionally rotates by 2^K and
// registers the {valid, data, shift} triple behind a bubble-collapsing ready.
module shift_rleft_stage
  import shift_barrelpipe_rleft_pkg::*;
#(
  parameter  int Bits = BITS_DFLT,
  parameter  int K    = 0,
  localparam int Log  = $clog2(Bits)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  input  logic [Bits-1:0] data_i,
  input  logic [Log-1:0]  sh_i,
  input  logic            rdy_next_i,
  output logic            rdy_o,
  output logic            valid_o,
  output logic [Bits-1:0] data_o,
  output logic [Log-1:0]  sh_o
);

  localparam int unsigned Amt = 32'd1 << K;

  typedef struct packed {
    logic            valid;
    logic [Bits-1:0] data;
    logic [Log-1:0]  sh;
  } rec_t;

  rec_t            st_q;
  rec_t            st_d;
  logic [Bits-1:0] rot_s;
  logic            rdy_s;

  // Fixed rotate of the incoming data by this level's weight.
  always_comb rot_s = Bits'(rotl(ROT_MAX'(data_i), Amt, Bits));

  // The stage can take new contents when it is empty or its successor moves.
  always_comb rdy_s = !st_q.valid || rdy_next_i;

  // Next-state: load from upstream when ready (bubbles clear valid), else hold.
  always_comb begin
    st_d = st_q;
    if (rdy_s) begin
      st_d.valid = valid_i;
      st_d.data  = sh_i[K] ? rot_s : data_i;
      st_d.sh    = sh_i;
    end else begin
      st_d = st_q;
    end
  end

  // Stage register; reset empties the stage and zeroes its payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign rdy_o   = rdy_s;
  assign valid_o = st_q.valid;
  assign data_o  = st_q.data;
  assign sh_o    = st_q.sh;

endmodule

// File: rtl/shift_barrelpipe_rleft.sv
// Pipelined rotate-left barrel shifter: Log rotate levels, one per stage,
// with a valid/retry handshake on both sides and bubble-collapsing advance.
module shift_barrelpipe_rleft
  import shift_barrelpipe_rleft_pkg::*;
#(
  parameter  int Bits = BITS_DFLT,
  localparam int Log  = $clog2(Bits)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_retry,
  input  logic [Bits-1:0] in_a,
  input  logic [Log-1:0]  in_sh,
  output logic            out_valid,
  input  logic            out_retry,
  output logic [Bits-1:0] out_b
);

  // Element 0 is the producer side; element k+1 is the output of stage k.
  logic            v_s [0:Log];
  logic [Bits-1:0] d_s [0:Log];
  logic [Log-1:0]  s_s [0:Log];

  assign v_s[0] = in_valid;
  assign d_s[0] = in_a;
  assign s_s[0] = in_sh;

  genvar k;
  for (k = 0; k < Log; k++) begin : g_stage
    logic rdy_w;
    logic rdy_next_w;

    // The last stage is gated by the consumer; earlier ones by their successor.
    if (k == Log - 1) begin : g_tail
      assign rdy_next_w = !out_retry;
    end else begin : g_link
      assign rdy_next_w = g_stage[k+1].rdy_w;
    end

    shift_rleft_stage #(
      .Bits (Bits),
      .K    (k)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .valid_i    (v_s[k]),
      .data_i     (d_s[k]),
      .sh_i       (s_s[k]),
      .rdy_next_i (rdy_next_w),
      .rdy_o      (rdy_w),
      .valid_o    (v_s[k+1]),
      .data_o     (d_s[k+1]),
      .sh_o       (s_s[k+1])
    );
  end

  // Retry is combinational from out_retry through the ready chain.
  assign in_retry  = !g_stage[0].rdy_w;
  assign out_valid = v_s[Log];
  assign out_b     = d_s[Log];

endmodule

// File: tb/tb_shift_barrelpipe_rleft.sv
// Self-checking bench for the pipelined rotate-left barrel shifter.
module tb_shift_barrelpipe_rleft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  // 64-bit instance
  logic        in_valid, in_retry, out_valid, out_retry;
  logic [63:0] in_a, out_b;
  logic [5:0]  in_sh;
  // 8-bit instance
  logic        in_valid8, in_retry8, out_valid8, out_retry8;
  logic [7:0]  in_a8, out_b8;
  logic [2:0]  in_sh8;

  shift_barrelpipe_rleft #(.Bits(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_retry(in_retry), .in_a(in_a), .in_sh(in_sh),
    .out_valid(out_valid), .out_retry(out_retry), .out_b(out_b)
  );

  shift_barrelpipe_rleft #(.Bits(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid8), .in_retry(in_retry8), .in_a(in_a8), .in_sh(in_sh8),
    .out_valid(out_valid8), .out_retry(out_retry8), .out_b(out_b8)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q [$];
  int          cyc = 0;
  int          n_out = 0;
  int          first_push = -1, first_pop = -1, last_pop = -1;
  bit          acc = 1'b0;

  typedef struct {
    logic [63:0] a;
    logic [5:0]  sh;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent bit-placement model of rotate-left on 64 bits.
  function automatic logic [63:0] ref_rotl(input logic [63:0] a, input int sh);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[(i + sh) % 64] = a[i];
    return r;
  endfunction

  // Called at posedge+1; records both handshakes of this cycle, then advances.
  task automatic cycle();
    #1;
    acc = in_valid && !in_retry;
    if (acc) begin
      exp_q.push_back(ref_rotl(in_a, int'(in_sh)));
      if (first_push < 0) first_push = cyc;
    end
    if (out_valid && !out_retry) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got %h, expected no result", out_b);
      end else begin
        chk("stream_data", out_b, exp_q.pop_front());
      end
      n_out++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run64(input string name, input logic [63:0] a, input logic [5:0] sh,
                       input logic [63:0] exp);
    int lat;
    in_valid = 1'b1; in_a = a; in_sh = sh;
    #1;
    chk({name, "_accept"}, {63'd0, in_retry}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_sh = sh + 6'd1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd6);
    chk({name, "_data"}, out_b, exp);
    @(posedge clk); #1;
    chk({name, "_single"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [2:0] sh,
                      input logic [7:0] exp);
    int lat;
    in_valid8 = 1'b1; in_a8 = a; in_sh8 = sh;
    #1;
    chk({name, "_accept"}, {63'd0, in_retry8}, 64'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_a8 = ~a;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd3);
    chk({name, "_data"}, {56'd0, out_b8}, {56'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    int          waitc;

    vecs[0] = '{64'h0123456789ABCDEF, 6'd4,  64'h123456789ABCDEF0};
    vecs[1] = '{64'h8000000000000001, 6'd0,  64'h8000000000000001};
    vecs[2] = '{64'h8000000000000001, 6'd63, 64'hC000000000000000};
    vecs[3] = '{64'h0000000000000001, 6'd32, 64'h0000000100000000};
    vecs[4] = '{64'h00000000000000FF, 6'd60, 64'hF00000000000000F};
    vecs[5] = '{64'hDEADBEEF00000000, 6'd1,  64'hBD5B7DDE00000001};
    vecs[6] = '{64'hAAAAAAAAAAAAAAAA, 6'd1,  64'h5555555555555555};
    vecs[7] = '{64'h0000000000000001, 6'd31, 64'h0000000080000000};

    reset_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_sh = '0; out_retry = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_sh8 = '0; out_retry8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_b", out_b, 64'd0);
    chk("reset_in_retry", {63'd0, in_retry}, 64'd0);
    chk("reset_out_valid8", {63'd0, out_valid8}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed single transactions, 64-bit
    for (int i = 0; i < 8; i++) run64($sformatf("vec%0d", i), vecs[i].a, vecs[i].sh, vecs[i].exp);

    // 8-bit instance, three levels
    run8("b8_a5", 8'hA5, 3'd3, 8'h2D);
    run8("b8_81_1", 8'h81, 3'd1, 8'h03);
    run8("b8_81_7", 8'h81, 3'd7, 8'hC0);

    // 100 back-to-back random requests
    exp_q.delete(); n_out = 0; first_push = -1; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_a = {$urandom(), $urandom()}; in_sh = 6'($urandom_range(0, 63));
      cycle();
    end
    in_valid = 1'b0;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 20) begin cycle(); waitc++; end
    chk("stream_count", 64'(n_out), 64'd100);
    chk("stream_fill_latency", 64'(first_pop - first_push), 64'd6);
    chk("stream_gapless", 64'(last_pop - first_pop), 64'd99);

    // Output stall of 10 cycles during a stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = {$urandom(), $urandom()}; in_sh = 6'($urandom_range(0, 63));
      cycle();
    end
    out_retry = 1'b1;
    held = out_b;
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (acc) begin in_a = {$urandom(), $urandom()}; in_sh = 6'($urandom_range(0, 63)); end
      cycle();
      chk("stall_hold", out_b, held);
    end
    chk("stall_in_retry", {63'd0, in_retry}, 64'd1);
    chk("stall_entries", 64'(exp_q.size()), 64'd6);
    out_retry = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", {63'd0, out_valid}, 64'd1);
      cycle();
    end
    chk("drain_done", {63'd0, out_valid}, 64'd0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with 4 requests in flight
    out_retry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = {$urandom(), $urandom()} | 64'd1; in_sh = 6'($urandom_range(0, 63));
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_reset_entries", 64'(exp_q.size()), 64'd4);
    reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_out_b", out_b, 64'd0);
    chk("midreset_in_retry", {63'd0, in_retry}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; out_retry = 1'b0; n_out = 0;
    repeat (12) cycle();
    chk("no_stale_result", 64'(n_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
